enemy_shooter: RTL and testbench
================================

Name: enemy_shooter

Overview:
- Enemy-side counterpart of the player ship. It launches enemy bullets from formation coordinates, moves them down the screen on the frame tick, and collision-tests them against the player's left/right extent.
- Produces the one-cycle hit pulse the player consumes as its hit input.
- Freezes bullets while the player is in its lost-life pause and clears them on resume.
- Exports bullet positions to the VGA renderer.

Parameters:
- slots_p, 2, number of simultaneous enemy bullets.
- speed_p, 4, pixels moved down per tick_i.
- player_top_p, 440, first screen row of the player ship.
- player_h_p, 16, player ship height in rows.
- screen_bottom_p, 479, last visible row.
- cooldown_p, 8, minimum ticks between accepted fires (optional feature only).

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous active-high reset.
- tick_i  input  1  one-cycle frame strobe that advances bullets.
- fire_i  input  1  request to launch a bullet.
- fire_x_i  input  10  launch column.
- fire_y_i  input  10  launch row.
- pos_left_i  input  10  player leftmost column, inclusive.
- pos_right_i  input  10  player rightmost column, inclusive.
- resume_i  input  1  player resume (shoot button) while in hold.
- fire_ready_o  output  1  at least one free slot and firing permitted.
- hit_o  output  1  one-cycle pulse; the player was struck.
- holding_o  output  1  block is in HIT_HOLD.
- bullet_valid_o  output  slots_p  slot i active.
- bullet_x_o  output  10*slots_p  slot i column at [10i+9:10i].
- bullet_y_o  output  10*slots_p  slot i row at [10i+9:10i].

Behaviour:
- Clock and reset:
  - One clock, clk_i. reset_i is synchronous and active-high. All state updates occur on the clk_i rising edge.
- Reset values:
  - state = RUN.
  - All bullet_valid_o = 0; bullet_x_o = 0; bullet_y_o = 0.
  - hit_o = 0; holding_o = 0; fire_ready_o = 1.
  - Reset mid-flight clears every slot on the next edge.
- Global FSM states: RUN and HIT_HOLD.
- Firing (RUN only):
  - When fire_i = 1 and a slot is free, the lowest-index free slot loads fire_x_i/fire_y_i and sets valid on the next edge.
  - Fire with no free slot is dropped silently.
  - fire_ready_o is combinational: state == RUN && any slot free (&& cooldown expired when the feature is enabled).
- Movement (RUN only), on tick_i:
  - Each slot that was active before this edge updates: y_next = y + speed_p.
  - The add is 11 bits wide. If y_next > screen_bottom_p, the slot is freed (valid = 0, coordinates unchanged).
- Fire and tick in the same cycle:
  - The newly loaded bullet keeps fire_y_i unmoved. Existing bullets move normally.
- Collision:
  - Evaluated on y_next for each moving slot.
  - A hit requires player_top_p <= y_next <= player_top_p + player_h_p - 1 and pos_left_i <= x <= pos_right_i, both bounds inclusive.
  - Every hitting slot is freed.
  - If any slot hits: hit_o = 1 for exactly one cycle (registered, the cycle after the tick edge) and state → HIT_HOLD.
  - Multiple simultaneous hits still produce a single pulse.
- HIT_HOLD:
  - holding_o = 1. Ticks are ignored and non-hitting bullets stay frozen at their positions. fire_i is dropped and fire_ready_o = 0.
  - resume_i = 1 clears all slots and returns to RUN on the next edge.
  - resume_i in RUN has no effect.
- Player extent:
  - pos_left_i > pos_right_i means no column can match, so no hit occurs.

Optional Feature:
- Macro: ENEMY_SHOOTER_COOLDOWN_EN.
- Defined:
  - A 4-bit or wider counter loads cooldown_p on each accepted fire and decrements on tick_i in RUN, saturating at 0.
  - Fire is accepted only when the counter is 0.
  - The counter resets to 0 on reset_i and when resume_i clears the slots.
- Undefined:
  - No counter. A fire is accepted whenever a slot is free in RUN.

Test Plan:
- Hit:
  - Stimulus: fire x=100, y=400; left=90, right=120; 10 ticks.
  - Response: y steps 404..440; hit_o pulses once after tick 10; holding_o = 1; slot 0 valid = 0.
- Miss/off-screen:
  - Stimulus: same fire; left=200, right=230.
  - Response: y reaches 476 after tick 19; tick 20 frees the slot; hit_o never asserted.
- Full:
  - Stimulus: three fires on consecutive cycles, no ticks.
  - Response: slots 0 and 1 valid; third fire dropped; fire_ready_o = 0 after the second fire.
- Hold/resume:
  - Stimulus: after a hit, with slot 1 active at y=300, apply 5 ticks and a fire, then resume_i.
  - Response: slot 1 stays at y=300; fire dropped; after resume, all valid = 0, state RUN, fire_ready_o = 1.
- Fire+tick coincidence:
  - Stimulus: slot 0 at y=200; same cycle fire x=50, y=100 and tick.
  - Response: slot 0 y=204; slot 1 y=100.
- Reset and cooldown:
  - Stimulus: reset_i mid-flight.
  - Response: all outputs return to their reset values next cycle.
  - With ENEMY_SHOOTER_COOLDOWN_EN: a second fire within 8 ticks is dropped; a fire after the 8th tick is accepted.

Source files
------------

// File: rtl/enemy_shooter_if.sv
// Bundles the enemy shooter's control inputs, player extent and bullet outputs.
// The design sits on the slave side; the driver (player/renderer glue or a bench) on the master side.
interface enemy_shooter_if #(
    parameter int slots_p = 2
);
    logic                    tick_i;
    logic                    fire_i;
    logic [9:0]              fire_x_i;
    logic [9:0]              fire_y_i;
    logic [9:0]              pos_left_i;
    logic [9:0]              pos_right_i;
    logic                    resume_i;
    logic                    fire_ready_o;
    logic                    hit_o;
    logic                    holding_o;
    logic [slots_p-1:0]      bullet_valid_o;
    logic [10*slots_p-1:0]   bullet_x_o;
    logic [10*slots_p-1:0]   bullet_y_o;

    modport slave (
        input  tick_i, fire_i, fire_x_i, fire_y_i, pos_left_i, pos_right_i, resume_i,
        output fire_ready_o, hit_o, holding_o, bullet_valid_o, bullet_x_o, bullet_y_o
    );

    modport master (
        output tick_i, fire_i, fire_x_i, fire_y_i, pos_left_i, pos_right_i, resume_i,
        input  fire_ready_o, hit_o, holding_o, bullet_valid_o, bullet_x_o, bullet_y_o
    );
endinterface

// File: rtl/enemy_shooter.sv
// Enemy bullet launcher/mover with player collision and lost-life hold.
// Optional fire cooldown counter enabled by defining ENEMY_SHOOTER_COOLDOWN_EN.
module enemy_shooter #(
    parameter int slots_p         = 2,
    parameter int speed_p         = 4,
    parameter int player_top_p    = 440,
    parameter int player_h_p      = 16,
    parameter int screen_bottom_p = 479
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
    ,
    parameter int cooldown_p      = 8
`endif
) (
    input  logic           clk_i,
    input  logic           reset_i,
    enemy_shooter_if.slave bus
);

    typedef enum logic {RUN, HIT_HOLD} state_t;

    localparam logic [10:0] speed_lp  = 11'(speed_p);
    localparam logic [10:0] bottom_lp = 11'(screen_bottom_p);
    localparam logic [10:0] top_lp    = 11'(player_top_p);
    localparam logic [10:0] last_lp   = 11'(player_top_p + player_h_p - 1);

    state_t                     state_q, state_d;
    logic [slots_p-1:0]         valid_q, valid_d;
    logic [slots_p-1:0][9:0]    x_q, x_d;
    logic [slots_p-1:0][9:0]    y_q, y_d;
    logic                       hit_q, hit_d;
    logic                       fire_ok;
    logic                       cd_zero;

`ifdef ENEMY_SHOOTER_COOLDOWN_EN
    localparam int cd_w_lp = ($clog2(cooldown_p + 1) < 4) ? 4 : $clog2(cooldown_p + 1);
    logic [cd_w_lp-1:0] cd_q, cd_d;
    assign cd_zero = (cd_q == '0);
`else
    assign cd_zero = 1'b1;
`endif

    assign fire_ok = (state_q == RUN) && !(&valid_q) && cd_zero;

    always_comb begin
        logic [10:0] y_nx;
        logic        any_hit;
        logic        slot_found;
        state_d    = state_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        hit_d      = 1'b0;
        y_nx       = '0;
        any_hit    = 1'b0;
        slot_found = 1'b0;
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
        cd_d       = cd_q;
`endif
        case (state_q)
            RUN: begin
                if (bus.tick_i) begin
                    for (int i = 0; i < slots_p; i++) begin
                        if (valid_q[i]) begin
                            y_nx = {1'b0, y_q[i]} + speed_lp;
                            if (y_nx > bottom_lp) begin
                                valid_d[i] = 1'b0;
                            end else begin
                                y_d[i] = y_nx[9:0];
                                if (y_nx >= top_lp && y_nx <= last_lp &&
                                    x_q[i] >= bus.pos_left_i && x_q[i] <= bus.pos_right_i) begin
                                    valid_d[i] = 1'b0;
                                    any_hit    = 1'b1;
                                end
                            end
                        end
                    end
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
                    if (!cd_zero) cd_d = cd_q - 1'b1;
`endif
                end
                // Slot choice uses pre-edge occupancy, so a freshly loaded bullet is never moved.
                if (bus.fire_i && fire_ok) begin
                    for (int i = 0; i < slots_p; i++) begin
                        if (!slot_found && !valid_q[i]) begin
                            slot_found = 1'b1;
                            valid_d[i] = 1'b1;
                            x_d[i]     = bus.fire_x_i;
                            y_d[i]     = bus.fire_y_i;
                        end
                    end
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
                    cd_d = cd_w_lp'(cooldown_p);
`endif
                end
                if (any_hit) begin
                    state_d = HIT_HOLD;
                    hit_d   = 1'b1;
                end
            end
            HIT_HOLD: begin
                if (bus.resume_i) begin
                    valid_d = '0;
                    state_d = RUN;
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
                    cd_d    = '0;
`endif
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RUN;
            valid_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hit_q   <= 1'b0;
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
            cd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hit_q   <= hit_d;
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
            cd_q    <= cd_d;
`endif
        end
    end

    assign bus.fire_ready_o   = fire_ok;
    assign bus.hit_o          = hit_q;
    assign bus.holding_o      = (state_q == HIT_HOLD);
    assign bus.bullet_valid_o = valid_q;
    assign bus.bullet_x_o     = x_q;
    assign bus.bullet_y_o     = y_q;

endmodule

// File: tb/tb_enemy_shooter.sv
// Bench for enemy_shooter: directed scenarios plus random traffic against a slot-level reference model.
module tb_enemy_shooter;
    localparam int SLOTS  = 2;
    localparam int SPEED  = 4;
    localparam int TOP    = 440;
    localparam int H      = 16;
    localparam int BOTTOM = 479;
    localparam int CD     = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enemy_shooter_if #(.slots_p(SLOTS)) bus();
    enemy_shooter #(.slots_p(SLOTS)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // reference model: per-slot occupancy and coordinates as plain integers
    int mv [SLOTS];
    int mx [SLOTS];
    int my [SLOTS];
    int mhold, mhit, mcd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            mv[i] = 0; mx[i] = 0; my[i] = 0;
        end
        mhold = 0; mhit = 0; mcd = 0;
    endtask

    task automatic model_update(input bit r, input bit t, input bit f, input int fx, input int fy,
                                input int l, input int rt, input bit res);
        int nhit, slot, yn;
        bit accept;
        if (r) begin
            model_reset();
            return;
        end
        nhit = 0;
        if (mhold == 0) begin
            slot = -1;
            for (int i = 0; i < SLOTS; i++) if (mv[i] == 0 && slot < 0) slot = i;
            accept = f && (slot >= 0) && (mcd == 0);
            if (t) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (mv[i] != 0) begin
                        yn = my[i] + SPEED;
                        if (yn > BOTTOM) mv[i] = 0;
                        else begin
                            my[i] = yn;
                            if (yn >= TOP && yn < TOP + H && mx[i] >= l && mx[i] <= rt) begin
                                mv[i] = 0;
                                nhit  = 1;
                            end
                        end
                    end
                end
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
                if (mcd > 0) mcd--;
`endif
            end
            if (accept) begin
                mv[slot] = 1; mx[slot] = fx; my[slot] = fy;
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
                mcd = CD;
`endif
            end
            if (nhit != 0) mhold = 1;
        end else if (res) begin
            for (int i = 0; i < SLOTS; i++) mv[i] = 0;
            mhold = 0;
            mcd   = 0;
        end
        mhit = nhit;
    endtask

    task automatic check_outputs();
        int free;
        free = 0;
        for (int i = 0; i < SLOTS; i++) if (mv[i] == 0) free = 1;
        chk("fire_ready", 32'(bus.fire_ready_o), 32'((mhold == 0) && (free != 0) && (mcd == 0)));
        chk("hit", 32'(bus.hit_o), 32'(mhit));
        chk("holding", 32'(bus.holding_o), 32'(mhold));
        for (int i = 0; i < SLOTS; i++) begin
            chk($sformatf("valid%0d", i), 32'(bus.bullet_valid_o[i]), 32'(mv[i]));
            chk($sformatf("x%0d", i), 32'(bus.bullet_x_o[10*i +: 10]), 32'(mx[i]));
            chk($sformatf("y%0d", i), 32'(bus.bullet_y_o[10*i +: 10]), 32'(my[i]));
        end
    endtask

    int cur_l = 90;
    int cur_r = 120;

    task automatic step(input bit r, input bit t, input bit f, input int fx, input int fy, input bit res);
        rst             = r;
        bus.tick_i      = t;
        bus.fire_i      = f;
        bus.fire_x_i    = 10'(fx);
        bus.fire_y_i    = 10'(fy);
        bus.pos_left_i  = 10'(cur_l);
        bus.pos_right_i = 10'(cur_r);
        bus.resume_i    = res;
        #1;
        check_outputs();
        model_update(r, t, f, fx, fy, cur_l, cur_r, res);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.tick_i = 0; bus.fire_i = 0; bus.fire_x_i = 0; bus.fire_y_i = 0;
        bus.pos_left_i = 0; bus.pos_right_i = 0; bus.resume_i = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();

        // hit: 10 ticks from y=400 reach 440 inside the player band
        cur_l = 90; cur_r = 120;
        step(0, 0, 1, 100, 400, 0);
        ticks(9);
        chk("hit_y_before", 32'(bus.bullet_y_o[9:0]), 32'd436);
        ticks(1);
        chk("hit_pulse", 32'(bus.hit_o), 32'd1);
        chk("hit_hold", 32'(bus.holding_o), 32'd1);
        chk("hit_slot_freed", 32'(bus.bullet_valid_o[0]), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("hit_single_pulse", 32'(bus.hit_o), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("resume_run", 32'(bus.holding_o), 32'd0);

        // miss and off-screen
        do_reset();
        cur_l = 200; cur_r = 230;
        step(0, 0, 1, 100, 400, 0);
        ticks(19);
        chk("miss_y476", 32'(bus.bullet_y_o[9:0]), 32'd476);
        ticks(1);
        chk("miss_freed", 32'(bus.bullet_valid_o[0]), 32'd0);
        chk("miss_no_hold", 32'(bus.holding_o), 32'd0);

        // full: three consecutive fires
        do_reset();
        step(0, 0, 1, 10, 10, 0);
        step(0, 0, 1, 20, 20, 0);
        step(0, 0, 1, 30, 30, 0);
`ifdef ENEMY_SHOOTER_COOLDOWN_EN
        chk("full_valid", 32'(bus.bullet_valid_o), 32'd1);
`else
        chk("full_valid", 32'(bus.bullet_valid_o), 32'd3);
        chk("full_not_ready", 32'(bus.fire_ready_o), 32'd0);
        chk("full_x1", 32'(bus.bullet_x_o[19:10]), 32'd20);
`endif

        // hold/resume with slot 1 frozen at y=300
        do_reset();
        cur_l = 90; cur_r = 120;
        step(0, 0, 1, 100, 368, 0);
        ticks(8);
        step(0, 0, 1, 500, 260, 0);
        ticks(10);
        chk("hold_hit", 32'(bus.holding_o), 32'd1);
        chk("hold_y1", 32'(bus.bullet_y_o[19:10]), 32'd300);
        ticks(5);
        step(0, 0, 1, 50, 50, 0);
        chk("hold_frozen_y1", 32'(bus.bullet_y_o[19:10]), 32'd300);
        chk("hold_fire_dropped", 32'(bus.bullet_valid_o), 32'd2);
        step(0, 0, 0, 0, 0, 1);
        chk("resume_cleared", 32'(bus.bullet_valid_o), 32'd0);
        chk("resume_ready", 32'(bus.fire_ready_o), 32'd1);

        // fire and tick in the same cycle
        do_reset();
        step(0, 0, 1, 10, 168, 0);
        ticks(8);
        step(0, 1, 1, 50, 100, 0);
        chk("coinc_y0", 32'(bus.bullet_y_o[9:0]), 32'd204);
        chk("coinc_y1", 32'(bus.bullet_y_o[19:10]), 32'd100);

        // reset mid-flight
        step(0, 1, 0, 0, 0, 0);
        do_reset();
        chk("rst_valid", 32'(bus.bullet_valid_o), 32'd0);
        chk("rst_x", 32'(bus.bullet_x_o), 32'd0);
        chk("rst_y", 32'(bus.bullet_y_o), 32'd0);
        chk("rst_ready", 32'(bus.fire_ready_o), 32'd1);

`ifdef ENEMY_SHOOTER_COOLDOWN_EN
        step(0, 0, 1, 10, 10, 0);
        ticks(7);
        step(0, 0, 1, 20, 20, 0);
        chk("cd_dropped", 32'(bus.bullet_valid_o), 32'd1);
        ticks(1);
        step(0, 0, 1, 30, 30, 0);
        chk("cd_accepted", 32'(bus.bullet_valid_o), 32'd3);
`endif

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit r, t, f, res;
            if ($urandom_range(0, 19) == 0) begin
                cur_l = $urandom_range(0, 639);
                cur_r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 639)
                                                    : cur_l + $urandom_range(0, 80);
            end
            r   = ($urandom_range(0, 299) == 0);
            t   = ($urandom_range(0, 2) == 0);
            f   = ($urandom_range(0, 3) == 0);
            res = ($urandom_range(0, 7) == 0);
            step(r, t, f, $urandom_range(0, 700), $urandom_range(300, 475), res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
